// File: rtl/aes_round_seq.sv
// -----------------------------------------------------------------------------
// aes_round_seq
//
// Iterative AES-128 encryption core. One round is computed per clock using
// an external 16-byte SubBytes array and an external round-key source, so the
// block itself holds only the 128-bit state, the round counter and the
// control FSM.
//
// Byte order: FIPS-197 byte k (k = row + 4*column) sits at bits
// [127-8k -: 8], i.e. byte 0 is the most significant byte.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   plaintext offered on in_data
//   in_ready   core is idle and can take a plaintext this cycle
//   in_data    128-bit plaintext
//   round_idx  index (0..10) of the round key that rkey must carry this cycle
//   rkey       round key for round_idx, combinational from round_idx
//   sb_in      current state, fed to the external SubBytes array
//   sb_out     SubBytes(sb_in), same byte positions, combinational
//   out_valid  ciphertext on out_data
//   out_ready  consumer takes the ciphertext
//   out_data   128-bit ciphertext
//
// Timing: the accepting edge performs key whitening, the next ten edges
// perform rounds 1..10, and out_valid is high after the tenth round edge.
// With out_ready held high a new block is taken every 12 cycles.
// -----------------------------------------------------------------------------
module aes_round_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   round_idx,
  input  logic [127:0] rkey,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [3:0] LAST_RND = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] sr_out;
  logic [127:0] mc_out;

  // ---------------------------------------------------------------------------
  // Round arithmetic
  // ---------------------------------------------------------------------------

  // Multiply by {02} in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated left by r byte positions across the four columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // One column times the circulant matrix {02 03 01 01}; 03*x is xtime(x)^x.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  assign sr_out = shift_rows(sb_out);
  assign mc_out = mix_columns(sr_out);

  // The state register is both the SubBytes operand and the result holder:
  // in DONE it is frozen, which keeps out_data stable under backpressure.
  assign sb_in    = state_q;
  assign out_data = state_q;

  // ---------------------------------------------------------------------------
  // Control: next state, next data, outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    round_idx = 4'd0;

    case (fsm_q)
      IDLE: begin
        in_ready  = 1'b1;
        round_idx = 4'd0;
        if (in_valid) begin
          state_d = in_data ^ rkey;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end

      ROUND: begin
        round_idx = rnd_q;
        // Treating any count >= 10 as the final round keeps rnd from
        // ever running past 10, even from a corrupted counter.
        if (rnd_q >= LAST_RND) begin
          state_d = sr_out ^ rkey;
          fsm_d   = DONE;
        end else begin
          state_d = mc_out ^ rkey;
          rnd_d   = rnd_q + 4'd1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        round_idx = LAST_RND;
        if (out_ready) begin
          rnd_d = 4'd0;
          fsm_d = IDLE;
        end
      end

      default: begin
        rnd_d = 4'd0;
        fsm_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// -----------------------------------------------------------------------------
// tb_aes_round_seq
//
// Directed bench for aes_round_seq. The bench provides the external SubBytes
// array (S-box table) and a round-key source driven by round_idx (AES-128 key
// expansion). Expected ciphertexts are the FIPS-197 Appendix B and C.1
// vectors; the whitened states are plaintext XOR key.
// -----------------------------------------------------------------------------
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   round_idx;
  logic [127:0] rkey;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] WHITE_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] WHITE_C = 128'h00102030405060708090a0b0c0d0e0f0;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] rk [11];

  aes_round_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .round_idx (round_idx),
    .rkey      (rkey),
    .sb_in     (sb_in),
    .sb_out    (sb_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // External SubBytes array.
  always_comb begin
    sb_out = '0;
    for (int k = 0; k < 16; k++) begin
      sb_out[127 - 8*k -: 8] = sbox(sb_in[127 - 8*k -: 8]);
    end
  end

  // External round-key source.
  always_comb begin
    rkey = '0;
    if (round_idx <= 4'd10) rkey = rk[round_idx];
  end

  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
            ^ {rcon(i / 4), 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("rdy_vld_excl", {127'b0, in_ready & out_valid}, 128'd0);
  endtask

  task automatic wait_valid(input int max, output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < max) begin
      tick();
      edges++;
    end
    chk("valid_seen", {127'b0, out_valid}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int t0;
    int t1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    load_key(KEY_B);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready",  {127'b0, in_ready},  128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_data",  out_data,            128'd0);
    chk("rst_round_idx", {124'b0, round_idx}, 128'd0);

    // App. B with edge-exact latency
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("b_white",    sb_in,               WHITE_B);
    chk("b_idx1",     {124'b0, round_idx}, 128'd1);
    chk("b_busy",     {127'b0, in_ready},  128'd0);
    for (int i = 1; i <= 9; i++) tick();
    chk("b_no_vld_e9", {127'b0, out_valid}, 128'd0);
    chk("b_idx10",     {124'b0, round_idx}, 128'd10);
    tick();
    chk("b_vld_e10",  {127'b0, out_valid}, 128'd1);
    chk("b_ct",       out_data,            CT_B);
    chk("b_done_idx", {124'b0, round_idx}, 128'd10);

    // Backpressure, with an ignored plaintext offer in DONE
    in_valid = 1'b1;
    in_data  = PT_C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data",     out_data,            CT_B);
      chk("bp_in_ready", {127'b0, in_ready},  128'd0);
      chk("bp_valid",    {127'b0, out_valid}, 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_idle",  {127'b0, in_ready},  128'd1);
    chk("hs_valid", {127'b0, out_valid}, 128'd0);
    chk("hs_idx",   {124'b0, round_idx}, 128'd0);

    // App. C.1 with in_valid held and in_data changing during rounds
    load_key(KEY_C);
    in_data  = PT_C;
    in_valid = 1'b1;
    tick();
    chk("c_white", sb_in, WHITE_C);
    for (int i = 0; i < 10; i++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    chk("c_valid", {127'b0, out_valid}, 128'd1);
    chk("c_ct",    out_data,            CT_C);
    in_data   = PT_C;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("c_hs_idle", {127'b0, in_ready}, 128'd1);
    tick();
    chk("c2_busy",  {127'b0, in_ready}, 128'd0);
    chk("c2_white", sb_in,              WHITE_C);
    in_valid = 1'b0;
    wait_valid(20, e);
    chk("c2_lat", 128'(e), 128'd10);
    chk("c2_ct",  out_data, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset at round 5, asserted together with in_valid and out_ready
    load_key(KEY_B);
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("r5_idx", {124'b0, round_idx}, 128'd5);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("r_in_ready",  {127'b0, in_ready},  128'd1);
    chk("r_out_valid", {127'b0, out_valid}, 128'd0);
    chk("r_out_data",  out_data,            128'd0);
    chk("r_idx",       {124'b0, round_idx}, 128'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("r_no_vld", {127'b0, out_valid}, 128'd0);
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(20, e);
    chk("r_b_lat", 128'(e), 128'd10);
    chk("r_b_ct",  out_data, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back App. B then App. C.1 with out_ready held high
    out_ready = 1'b1;
    in_data   = PT_B;
    in_valid  = 1'b1;
    tick();
    t0      = cyc;
    in_data = PT_C;
    wait_valid(20, e);
    chk("bb_b_ct", out_data, CT_B);
    load_key(KEY_C);
    tick();
    chk("bb_idle", {127'b0, in_ready}, 128'd1);
    tick();
    t1 = cyc;
    in_valid = 1'b0;
    chk("bb_gap",   128'(t1 - t0), 128'd12);
    chk("bb_white", sb_in,         WHITE_C);
    wait_valid(20, e);
    chk("bb_c_ct", out_data, CT_C);
    tick();
    chk("bb_end_idle", {127'b0, in_ready}, 128'd1);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
